// File: rtl/cam_pkg.sv
// Shared default sizing for the CAM lookup block.
// No ports; imported by cam and cam_prio_enc.
package cam_pkg;

  localparam int CAM_DATA_W = 8;   // stored word / search key width
  localparam int CAM_ADDR_W = 5;   // write address and result index width
  localparam int CAM_DEPTH  = 16;  // number of entries, must be <= 2**CAM_ADDR_W

endpackage : cam_pkg

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder: reports whether any request bit is set and
// the index of the lowest set bit (bit 0 has the highest priority).
// Ports:
//   i_req  N-bit request vector
//   o_any  1 when at least one request bit is set
//   o_idx  index of the lowest set bit, 0 when none is set
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int N     = CAM_DEPTH,
  parameter int IDX_W = CAM_ADDR_W
) (
  input  logic [N-1:0]     i_req,
  output logic             o_any,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from the top down so the last assignment is the lowest set bit.
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_any = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule : cam_prio_enc

// File: rtl/cam.sv
// Small synchronous content-addressable memory used for tag lookup.
// DEPTH entries of DATA_W bits, each with a valid bit. A write stores data at
// addr; a search compares data against every valid entry in parallel and
// registers the lowest matching index and a hit flag one clock later.
// Ports:
//   out     registered index of the lowest matching entry (0 on a miss)
//   found   registered hit flag for the last search
//   clk     clock, rising edge
//   enable  search request
//   rst_n   asynchronous active-low reset (clears valid bits and outputs)
//   write   write request, takes priority over enable
//   addr    write address; addresses >= DEPTH are ignored
//   data    write data or search key
// DEPTH must not exceed 2**ADDR_W.
module cam
  import cam_pkg::*;
#(
  parameter int DATA_W = CAM_DATA_W,
  parameter int ADDR_W = CAM_ADDR_W,
  parameter int DEPTH  = CAM_DEPTH
) (
  output logic [ADDR_W-1:0] out,
  output logic              found,
  input  logic              clk,
  input  logic              enable,
  input  logic              rst_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  w_wr_sel;
  logic [DEPTH-1:0]  w_match;
  logic              w_any;
  logic [ADDR_W-1:0] w_idx;
  logic [ADDR_W-1:0] r_out_p1;
  logic              r_found_p1;

  // Full-width address compare per entry: an out-of-range address selects
  // nothing, so such writes drop out without a separate range check.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    assign w_wr_sel[g] = write && (addr == ADDR_W'(g));
    assign w_match[g]  = r_valid[g] && (r_mem[g] == data);
  end

  // Storage words carry no reset; the valid bits alone gate matching.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wr_sel[i]) r_mem[i] <= data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_valid <= '0;
    else        r_valid <= r_valid | w_wr_sel;
  end

  cam_prio_enc #(
    .N     (DEPTH),
    .IDX_W (ADDR_W)
  ) u_prio_enc (
    .i_req (w_match),
    .o_any (w_any),
    .o_idx (w_idx)
  );

  // ---- stage p1: registered search result ----
  // A write in the same cycle suppresses the search; results hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_p1   <= '0;
      r_found_p1 <= 1'b0;
    end else if (enable && !write) begin
      r_out_p1   <= w_idx;
      r_found_p1 <= w_any;
    end
  end

  assign out   = r_out_p1;
  assign found = r_found_p1;

endmodule : cam

// File: tb/tb_cam.sv
module tb_cam;

  typedef struct {
    logic       wr;
    logic       en;
    logic [4:0] addr;
    logic [7:0] data;
    logic       ef;
    logic [4:0] eo;
    string      nm;
  } vec_t;

  typedef struct {
    logic       ef;
    logic [4:0] eo;
    string      nm;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       write;
  logic [4:0] addr;
  logic [7:0] data;
  logic [4:0] out;
  logic       found;
  bit         clk_run;

  int checks;
  int errors;

  vec_t tbl[$];
  exp_t sb[$];

  cam dut (
    .out    (out),
    .found  (found),
    .clk    (clk),
    .enable (enable),
    .rst_n  (rst_n),
    .write  (write),
    .addr   (addr),
    .data   (data)
  );

  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic af, input logic [4:0] ao,
                       input logic ef, input logic [4:0] eo);
    checks++;
    if (af !== ef || ao !== eo) begin
      errors++;
      $display("FAIL %s: got found=%b out=%0d, expected found=%b out=%0d",
               nm, af, ao, ef, eo);
    end
  endtask

  task automatic add(input logic wr, input logic en, input logic [4:0] a,
                     input logic [7:0] d, input logic ef, input logic [4:0] eo,
                     input string nm);
    vec_t v;
    v.wr = wr; v.en = en; v.addr = a; v.data = d;
    v.ef = ef; v.eo = eo; v.nm = nm;
    tbl.push_back(v);
  endtask

  // Drive one vector, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    write  = v.wr;
    enable = v.en;
    addr   = v.addr;
    data   = v.data;
    e.ef = v.ef; e.eo = v.eo; e.nm = v.nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      got = sb.pop_front();
      check(got.nm, found, out, got.ef, got.eo);
    end
  endtask

  task automatic run_table();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
    @(negedge clk);
    write  = 1'b0;
    enable = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    clk_run = 1'b0;
    write   = 1'b0;
    enable  = 1'b0;
    addr    = '0;
    data    = '0;
    rst_n   = 1'b1;

    // Asynchronous reset with the clock stopped.
    #1 rst_n = 1'b0;
    #2 check("reset_noclk", found, out, 1'b0, 5'd0);
    #2 rst_n = 1'b1;
    clk_run = 1'b1;

    // Invalid entries never match, even a zero key.
    add(0, 1, 5'd0, 8'h00, 0, 5'd0, "srch_00_after_reset");
    // Fill, then search each value.
    for (int i = 0; i < 16; i++)
      add(1, 0, 5'(i), 8'(8'h10 + i), 0, 5'd0, $sformatf("fill_wr_%0d", i));
    for (int i = 0; i < 16; i++)
      add(0, 1, 5'd0, 8'(8'h10 + i), 1, 5'(i), $sformatf("fill_srch_%0d", i));
    // Misses report out=0.
    add(0, 1, 5'd0, 8'h00, 0, 5'd0, "miss_00");
    add(0, 1, 5'd0, 8'hFF, 0, 5'd0, "miss_ff");
    add(0, 1, 5'd0, 8'h55, 0, 5'd0, "miss_55");
    // Duplicates: lowest index wins; overwrite removes the old value.
    add(1, 0, 5'd0,  8'hAA, 0, 5'd0, "dup_wr_0");
    add(1, 0, 5'd5,  8'hAA, 0, 5'd0, "dup_wr_5");
    add(1, 0, 5'd10, 8'hAA, 0, 5'd0, "dup_wr_10");
    add(0, 1, 5'd0,  8'hAA, 1, 5'd0, "dup_srch_lowest");
    add(1, 0, 5'd0,  8'h10, 1, 5'd0, "dup_overwrite_hold");
    add(0, 1, 5'd0,  8'hAA, 1, 5'd5, "dup_srch_after_ovw");
    run_table();

    // Mid-run asynchronous reset, checked before the next clock edge.
    #1 rst_n = 1'b0;
    #1 check("reset_midrun", found, out, 1'b0, 5'd0);
    #1 rst_n = 1'b1;

    add(0, 1, 5'd0,  8'hAA, 0, 5'd0, "srch_aa_after_reset");
    add(0, 1, 5'd0,  8'h13, 0, 5'd0, "srch_13_after_reset");
    // Write with enable: write happens, search suppressed.
    add(1, 0, 5'd2,  8'h44, 0, 5'd0, "corner_wr_2");
    add(0, 1, 5'd0,  8'h44, 1, 5'd2, "corner_srch_44");
    add(0, 1, 5'd0,  8'h99, 0, 5'd0, "corner_miss_99");
    add(1, 1, 5'd1,  8'h44, 0, 5'd0, "wr_en_hold");
    add(0, 1, 5'd0,  8'h44, 1, 5'd1, "wr_en_entry_written");
    // Idle holds even with a matching key on data.
    add(0, 1, 5'd0,  8'h99, 0, 5'd0, "idle_prep_miss");
    add(0, 0, 5'd0,  8'h44, 0, 5'd0, "idle_hold");
    // Out-of-range writes are dropped.
    add(1, 0, 5'd16, 8'h66, 0, 5'd0, "oor_wr_16");
    add(0, 1, 5'd0,  8'h66, 0, 5'd0, "oor_srch_66");
    add(1, 0, 5'd31, 8'h67, 0, 5'd0, "oor_wr_31");
    add(0, 1, 5'd0,  8'h67, 0, 5'd0, "oor_srch_67");
    add(0, 1, 5'd0,  8'h44, 1, 5'd1, "oor_entries_intact");
    run_table();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety bound so the bench always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule : tb_cam

// File: doc/cam.md
Name: cam

Overview:
- Small synchronous content-addressable memory: DEPTH entries of DATA_W bits, each with a valid bit.
- Write port stores `data` at `addr`.
- Search port compares `data` against all valid entries in parallel and registers the lowest matching address plus a hit flag.
- Used as a lookup/tag-match block inside the datapath.

Parameters:
- DATA_W, 8, width of each stored word and of the search key.
- ADDR_W, 5, width of `addr` and `out`.
- DEPTH, 16, number of entries; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- out  output  ADDR_W  registered index of the lowest matching entry.
- found  output  1  registered hit flag for the last search.
- enable  input  1  search request, sampled on the clk rising edge.
- write  input  1  write request, sampled on the clk rising edge; has priority over enable.
- addr  input  ADDR_W  write address.
- data  input  DATA_W  write data, or search key.

Instance port order is out, found, clk, enable, rst_n, write, addr, data.

Behaviour:
- Reset (rst_n=0, asynchronous, effective immediately, no clock needed):
  - all valid bits cleared;
  - out=0, found=0;
  - stored data words need not be cleared.
  - Reset asserted mid-operation aborts any pending write or search.
  - No entry matches after reset until it is rewritten.
- Write (write=1 at posedge):
  - if addr < DEPTH: mem[addr] <= data and valid[addr] <= 1;
  - if addr >= DEPTH: the write is silently ignored.
  - out and found hold their values.
  - Overwriting an entry replaces its old value; the old value no longer matches.
- Search (write=0, enable=1 at posedge):
  - match[i] = valid[i] && (mem[i] == data), combinationally over the contents present before the edge.
  - found <= |match.
  - out <= lowest i with match[i]=1, or 0 if there is no match.
  - Latency is 1 clock: results are valid after the edge and held until the next search or reset.
- write=1 and enable=1 together: write only; no search; outputs hold.
- write=0 and enable=0: idle; all state holds.
- Duplicates: when several entries match, the lowest index wins (priority encoder, index 0 highest priority).
- A miss always reports out=0 with found=0; out is qualified by found.
- No state machine beyond the storage, valid and output registers.

Decomposition:
- Package cam_pkg holds the DATA_W/ADDR_W/DEPTH default constants.
- One natural sub-module: cam_prio_enc, a parameterised DEPTH-input lowest-index priority encoder producing {any, index}.
- Storage, valid bits and match vector stay in cam.

Test Plan:
- Reset: rst_n low with no clock -> found=0, out=0 immediately; a search for 0x00 afterwards -> found=0, out=0. This checks that invalid entries never match a zero key.
- Fill: write 0x10+i to addr i for i=0..15, then search 0x10..0x1F one per cycle -> found=1, out=i one cycle after each search edge.
- Misses: with entries 0..15 still holding 0x10+i (not yet overwritten), search 0x00, 0xFF, 0x55 -> found=0, out=0 each.
- Duplicates: write 0xAA to addr 0, 5, 10, then search 0xAA -> found=1, out=0. Overwrite addr 0 with 0x10, search 0xAA again -> out=5.
- Reset clears: after the duplicates test, pulse rst_n low, then search 0xAA -> found=0, out=0.
- Priority and corners:
  - write=1 and enable=1 with a key present -> entry written, out/found unchanged;
  - write to addr 16 (>= DEPTH) -> no entry changes, and a subsequent search for that data misses.
